// File: rtl/pc_pkg.sv
// Shared types and constants for the IF-stage program-counter controller.
package pc_pkg;

    localparam int PC_W_DEF = 16;
    localparam int BUB_W    = 2;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    // The countdown starts at bubbles-1 so that FLUSH lasts exactly that many cycles.
    function automatic logic [BUB_W-1:0] bubble_load(input int n);
        logic [BUB_W-1:0] v;
        v = '0;
        if (n > 0) begin
            v = BUB_W'(n - 1);
        end
        return v;
    endfunction

endpackage

// File: rtl/pc_bubble_counter.sv
// Down-counter that paces the FLUSH bubbles after a redirect.
module pc_bubble_counter
    import pc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [BUB_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [BUB_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// IF-stage PC owner: sequential advance under a valid/ready handshake, redirects with bubbles.
// Optional redirect counter enabled by defining PC_FETCH_REDIRECT_CNT_EN.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int              PC_W          = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC      = '0,
    parameter int              PC_INC        = 2,
    parameter int              FLUSH_BUBBLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_target_i,
    input  logic            fetch_ready_i,
    output logic [PC_W-1:0] fetch_pc_o,
    output logic            fetch_valid_o,
    output logic [PC_W-1:0] next_seq_pc_o,
    output logic            misalign_o,
    output logic [15:0]     redirect_count_o
);

    localparam logic [BUB_W-1:0] BUB_LOAD = bubble_load(FLUSH_BUBBLES);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_next_seq;
    logic [PC_W-1:0] w_target;
    logic            w_tgt_misaligned;
    logic            r_misalign;
    logic            w_bub_load;
    logic            w_bub_dec;
    logic            w_bub_zero;

    assign w_next_seq = r_pc + PC_W'(PC_INC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (redirect_i && w_tgt_misaligned) begin
                r_misalign <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_bub_load       = 1'b0;
        w_bub_dec        = 1'b0;
        w_target         = redirect_target_i;
        w_tgt_misaligned = (PC_INC == 2) && redirect_target_i[0];
        if (w_tgt_misaligned) begin
            w_target[0] = 1'b0;
        end

        case (r_state)
            BOOT: begin
                w_state_next = RUN;
            end
            RUN: begin
                if (fetch_ready_i && !stall_i) begin
                    w_pc_next = w_next_seq;
                end
            end
            FLUSH: begin
                if (w_bub_zero) begin
                    w_state_next = RUN;
                end else begin
                    w_bub_dec = 1'b1;
                end
            end
            default: begin
                w_state_next = BOOT;
            end
        endcase

        // A redirect overrides stall, backpressure and any bubble in progress.
        if (redirect_i) begin
            w_pc_next  = w_target;
            w_bub_dec  = 1'b0;
            if (FLUSH_BUBBLES == 0) begin
                w_state_next = RUN;
            end else begin
                w_state_next = FLUSH;
                w_bub_load   = 1'b1;
            end
        end
    end

    pc_bubble_counter u_bubble_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_bub_load),
        .i_load_val (BUB_LOAD),
        .i_dec      (w_bub_dec),
        .o_zero     (w_bub_zero)
    );

`ifdef PC_FETCH_REDIRECT_CNT_EN
    logic [15:0] r_redirect_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_cnt <= 16'h0000;
        end else if (redirect_i && (r_redirect_cnt != 16'hFFFF)) begin
            r_redirect_cnt <= r_redirect_cnt + 16'h0001;
        end
    end

    assign redirect_count_o = r_redirect_cnt;
`else
    assign redirect_count_o = 16'h0000;
`endif

    assign fetch_pc_o    = r_pc;
    assign fetch_valid_o = (r_state == RUN);
    assign next_seq_pc_o = w_next_seq;
    assign misalign_o    = r_misalign;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed + randomized bench for pc_fetch_ctrl against a cycle-level behavioural model.
module tb_pc_fetch_ctrl;

    localparam int INC = 2;
    localparam int NB  = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [15:0] redirect_target_i = 16'h0000;
    logic        fetch_ready_i = 1'b0;
    logic [15:0] fetch_pc_o;
    logic        fetch_valid_o;
    logic [15:0] next_seq_pc_o;
    logic        misalign_o;
    logic [15:0] redirect_count_o;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_pc;
    bit          m_boot;
    int          m_bub;
    bit          m_mis;
    int          m_cnt;

    pc_fetch_ctrl #(
        .PC_W          (16),
        .RESET_PC      (16'h0000),
        .PC_INC        (INC),
        .FLUSH_BUBBLES (NB)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .fetch_ready_i     (fetch_ready_i),
        .fetch_pc_o        (fetch_pc_o),
        .fetch_valid_o     (fetch_valid_o),
        .next_seq_pc_o     (next_seq_pc_o),
        .misalign_o        (misalign_o),
        .redirect_count_o  (redirect_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
        end
    endtask

    function automatic bit m_valid();
        return !m_boot && (m_bub == 0);
    endfunction

    task automatic model_reset();
        m_pc   = 16'h0000;
        m_boot = 1'b1;
        m_bub  = 0;
        m_mis  = 1'b0;
        m_cnt  = 0;
    endtask

    // Effect of one clock edge, stated directly from the fetch rules.
    task automatic model_step(input bit st, input bit rdy, input bit rd, input logic [15:0] tgt);
        if (rd) begin
            m_pc = tgt;
            if (INC == 2 && tgt[0]) begin
                m_pc[0] = 1'b0;
                m_mis   = 1'b1;
            end
            m_bub  = NB;
            m_boot = 1'b0;
`ifdef PC_FETCH_REDIRECT_CNT_EN
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_bub > 0) begin
            m_bub = m_bub - 1;
        end else if (rdy && !st) begin
            m_pc = m_pc + 16'(INC);
        end
    endtask

    // Starts and ends 1 time unit after a rising edge.
    task automatic cycle(input bit st, input bit rdy, input bit rd, input logic [15:0] tgt,
                         input bit chk, input bit dchk, input logic [15:0] exp_pc, input bit exp_v);
        stall_i           = st;
        fetch_ready_i     = rdy;
        redirect_i        = rd;
        redirect_target_i = tgt;
        @(negedge clk);
        if (dchk) begin
            check("dir_pc", fetch_pc_o, exp_pc);
            check("dir_valid", 16'(fetch_valid_o), 16'(exp_v));
        end
        if (chk) begin
            check("pc", fetch_pc_o, m_pc);
            check("valid", 16'(fetch_valid_o), 16'(m_valid()));
            check("next_seq", next_seq_pc_o, m_pc + 16'(INC));
            check("misalign", 16'(misalign_o), 16'(m_mis));
            check("count", redirect_count_o, 16'(m_cnt));
        end
        @(posedge clk);
        model_step(st, rdy, rd, tgt);
        #1;
    endtask

    task automatic d(input bit st, input bit rdy, input bit rd, input logic [15:0] tgt,
                     input logic [15:0] exp_pc, input bit exp_v);
        cycle(st, rdy, rd, tgt, 1'b1, 1'b1, exp_pc, exp_v);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_pc"}, fetch_pc_o, 16'h0000);
        check({tag, "_valid"}, 16'(fetch_valid_o), 16'h0000);
        check({tag, "_misalign"}, 16'(misalign_o), 16'h0000);
        check({tag, "_count"}, redirect_count_o, 16'h0000);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", fetch_pc_o, 16'h0000);
        check("rst_valid", 16'(fetch_valid_o), 16'h0000);
        check("rst_misalign", 16'(misalign_o), 16'h0000);
        check("rst_count", redirect_count_o, 16'h0000);
        rst_n = 1'b1;

        // Boot and sequential advance
        d(0, 1, 0, 16'h0000, 16'h0000, 0);
        d(0, 1, 0, 16'h0000, 16'h0000, 1);
        d(0, 1, 0, 16'h0000, 16'h0002, 1);
        d(0, 1, 0, 16'h0000, 16'h0004, 1);
        // Backpressure and stall hold
        for (int i = 0; i < 3; i++) d(0, 0, 0, 16'h0000, 16'h0006, 1);
        d(0, 1, 0, 16'h0000, 16'h0006, 1);
        for (int i = 0; i < 2; i++) d(1, 1, 0, 16'h0000, 16'h0008, 1);
        d(0, 1, 0, 16'h0000, 16'h0008, 1);
        // Redirect with one bubble
        d(0, 1, 1, 16'h0040, 16'h000A, 1);
        d(0, 1, 0, 16'h0000, 16'h0040, 0);
        d(0, 1, 0, 16'h0000, 16'h0040, 1);
        // Redirect beats stall and backpressure; second redirect inside FLUSH
        d(1, 0, 1, 16'h0040, 16'h0042, 1);
        d(0, 1, 1, 16'h0080, 16'h0040, 0);
        d(0, 1, 0, 16'h0000, 16'h0080, 0);
        d(0, 1, 0, 16'h0000, 16'h0080, 1);
        d(0, 1, 0, 16'h0000, 16'h0082, 1);
        // Misaligned target
        d(0, 1, 1, 16'h0033, 16'h0084, 1);
        check("mis_set", 16'(misalign_o), 16'h0001);
        d(0, 1, 0, 16'h0000, 16'h0032, 0);
        d(0, 1, 0, 16'h0000, 16'h0032, 1);
        d(0, 1, 1, 16'h0010, 16'h0034, 1);
        check("mis_sticky", 16'(misalign_o), 16'h0001);
        d(0, 1, 0, 16'h0000, 16'h0010, 0);
        // Wrap-around
        d(0, 1, 1, 16'hFFFE, 16'h0010, 1);
        d(0, 1, 0, 16'h0000, 16'hFFFE, 0);
        check("wrap_nseq", next_seq_pc_o, 16'h0000);
        d(0, 1, 0, 16'h0000, 16'hFFFE, 1);
        d(0, 1, 0, 16'h0000, 16'h0000, 1);
        d(0, 0, 0, 16'h0000, 16'h0002, 1);

        async_reset("hs_reset");
        // Redirect during BOOT, then reset mid-FLUSH
        d(0, 1, 1, 16'h0055, 16'h0000, 0);
        check("boot_redirect_pc", fetch_pc_o, 16'h0054);
        check("boot_redirect_mis", 16'(misalign_o), 16'h0001);
        async_reset("flush_reset");

        for (int i = 0; i < 5; i++) d(0, 1, 1, 16'(16'h0100 + 16'(i * 4)), 16'(m_pc), m_valid());
`ifdef PC_FETCH_REDIRECT_CNT_EN
        check("count5", redirect_count_o, 16'h0005);
`else
        check("count_tied", redirect_count_o, 16'h0000);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) == 0), 16'($urandom), 1'b1, 1'b0, 16'h0000, 1'b0);
        end

`ifdef PC_FETCH_REDIRECT_CNT_EN
        for (int i = 0; i < 65535; i++) begin
            cycle(0, 1, 1, 16'h0200, 1'b0, 1'b0, 16'h0000, 1'b0);
        end
        check("count_sat", redirect_count_o, 16'hFFFF);
        cycle(0, 1, 1, 16'h0300, 1'b1, 1'b0, 16'h0000, 1'b0);
        check("count_hold", redirect_count_o, 16'hFFFF);
`else
        check("count_tied_end", redirect_count_o, 16'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
